// File: rtl/vdp_pkg.sv
// Shared VDP definitions: register map, write targets, STATUS layout and the
// queued VRAM write entry used by every VDP writer.
package vdp_pkg;

  localparam logic [1:0] REG_ADDR_LO = 2'd0;
  localparam logic [1:0] REG_ADDR_HI = 2'd1;
  localparam logic [1:0] REG_DATA    = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam logic TARGET_NAME = 1'b0;
  localparam logic TARGET_TILE = 1'b1;

  localparam int VRAM_AW = 12;

  localparam int ST_FULL    = 7;
  localparam int ST_EMPTY   = 6;
  localparam int ST_OVF     = 5;
  localparam int ST_PHASE   = 4;
  localparam int ST_CNT_LSB = 0;

  typedef struct packed {
    logic               target;
    logic [VRAM_AW-1:0] addr;
    logic [15:0]        data;
  } wr_entry_t;

endpackage

// File: rtl/vdp_wr_fifo.sv
// Synchronous write-entry FIFO with occupancy count and flush; pushes on full
// are dropped, flush overrides any push/pop in the same cycle.
module vdp_wr_fifo
  import vdp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  wr_entry_t        din_i,
  input  logic             pop_i,
  output wr_entry_t        dout_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  wr_entry_t        mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/vdp_host_port.sv
// CPU byte-register write port into VDP name/tile RAM with auto-incrementing pointer.
// Define VDP_HOST_IRQ_EN to add an irq output (drain complete / overflow, cleared by STATUS read).
module vdp_host_port
  import vdp_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic        dot_clk,
  input  logic        reset_n,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_reg,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic        wr_target,
  output logic [11:0] wr_addr,
  output logic [15:0] wr_data
`ifdef VDP_HOST_IRQ_EN
  ,
  output logic        irq
`endif
);

  logic [12:0]        ptr_q, ptr_d;
  logic               phase_q, phase_d;
  logic [7:0]         latch_q, latch_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               push, pop, flush, full, empty;
  logic               wr_acc, rd_acc;
  logic [VRAM_AW-1:0] ptr_inc;
  logic [CNT_W-1:0]   count;
  logic [7:0]         status;
  wr_entry_t          push_entry, head;

  assign wr_acc  = cpu_cs & cpu_we;
  assign rd_acc  = cpu_cs & ~cpu_we;
  assign ptr_inc = ptr_q[VRAM_AW-1:0] + 12'd1;
  assign pop     = wr_valid & wr_ready;

  always_comb begin
    status                     = '0;
    status[ST_FULL]            = full;
    status[ST_EMPTY]           = empty;
    status[ST_OVF]             = ovf_q;
    status[ST_PHASE]           = phase_q;
    status[ST_CNT_LSB +: 3]    = (32'(count) > 32'd7) ? 3'd7 : 3'(count);
  end

  always_comb begin
    ptr_d      = ptr_q;
    phase_d    = phase_q;
    latch_d    = latch_q;
    ovf_d      = ovf_q;
    rdata_d    = rdata_q;
    push       = 1'b0;
    flush      = 1'b0;
    push_entry = '0;
    if (wr_acc) begin
      case (cpu_reg)
        REG_ADDR_LO: ptr_d[7:0] = cpu_wdata;
        REG_ADDR_HI: begin
          ptr_d[12:8] = cpu_wdata[4:0];
          phase_d     = 1'b0;
        end
        REG_DATA: begin
          // ptr[12] picks the RAM; the increment only ever touches ptr[11:0].
          if (ptr_q[12] == TARGET_TILE) begin
            push              = 1'b1;
            push_entry.target = TARGET_TILE;
            push_entry.addr   = ptr_q[VRAM_AW-1:0];
            push_entry.data   = {8'h00, cpu_wdata};
            ptr_d[11:0]       = ptr_inc;
          end else if (!phase_q) begin
            latch_d = cpu_wdata;
            phase_d = 1'b1;
          end else begin
            push              = 1'b1;
            push_entry.target = TARGET_NAME;
            push_entry.addr   = ptr_q[VRAM_AW-1:0];
            push_entry.data   = {latch_q, cpu_wdata};
            ptr_d[11:0]       = ptr_inc;
            phase_d           = 1'b0;
          end
        end
        default: begin
          if (cpu_wdata[0]) begin
            flush   = 1'b1;
            ovf_d   = 1'b0;
            phase_d = 1'b0;
          end
        end
      endcase
    end
    if (push && full) ovf_d = 1'b1;
    if (rd_acc) begin
      case (cpu_reg)
        REG_ADDR_LO: rdata_d = ptr_q[7:0];
        REG_ADDR_HI: rdata_d = {3'b000, ptr_q[12:8]};
        REG_DATA:    rdata_d = 8'h00;
        default:     rdata_d = status;
      endcase
    end
  end

  always_ff @(posedge dot_clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= '0;
      phase_q <= 1'b0;
      latch_q <= '0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      phase_q <= phase_d;
      latch_q <= latch_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

  vdp_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (dot_clk),
    .rst_n_i (reset_n),
    .flush_i (flush),
    .push_i  (push),
    .din_i   (push_entry),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign cpu_rdata = rdata_q;
  assign wr_valid  = ~empty;
  assign wr_target = head.target;
  assign wr_addr   = head.addr;
  assign wr_data   = head.data;

`ifdef VDP_HOST_IRQ_EN
  logic irq_q, irq_set;

  // A push accepted alongside the last pop keeps the FIFO non-empty: no drain event.
  assign irq_set = (pop && !flush && (count == CNT_W'(1)) && !(push && !full))
                 || (push && full);

  always_ff @(posedge dot_clk or negedge reset_n) begin
    if (!reset_n)                             irq_q <= 1'b0;
    else if (irq_set)                         irq_q <= 1'b1;
    else if (rd_acc && cpu_reg == REG_CTRL)   irq_q <= 1'b0;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_vdp_host_port.sv
// Bench for vdp_host_port: directed scenarios plus random register traffic,
// channel beats checked against a queue filled by a behavioural model.
module tb_vdp_host_port;

  localparam int DEPTH = 4;

  logic        dot_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_cs = 1'b0, cpu_we = 1'b0;
  logic [1:0]  cpu_reg = 2'd0;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic        wr_valid, wr_target;
  logic        wr_ready = 1'b0;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic [28:0] head;

  int n_checks = 0;
  int n_errs   = 0;

  // reference model: pointer as an integer 0..8191, FIFO as a queue of expected beats
  int m_ptr = 0, m_phase = 0, m_latch = 0, m_ovf = 0, m_cnt = 0;
  logic [28:0] sb[$];

  always #5 dot_clk = ~dot_clk;

  vdp_host_port dut (
    .dot_clk   (dot_clk),
    .reset_n   (reset_n),
    .cpu_cs    (cpu_cs),
    .cpu_we    (cpu_we),
    .cpu_reg   (cpu_reg),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_target (wr_target),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  assign head = {wr_target, wr_addr, wr_data};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ptr = 0; m_phase = 0; m_latch = 0; m_ovf = 0; m_cnt = 0;
    sb.delete();
  endfunction

  function automatic void model_step(input bit cs, input bit we, input bit [1:0] r, input bit [7:0] d);
    bit          pop;
    bit          push;
    logic [28:0] e;
    pop  = wr_ready && (m_cnt > 0);
    push = 0;
    e    = '0;
    if (cs && we) begin
      case (r)
        2'd0: m_ptr = (m_ptr / 256) * 256 + int'(d);
        2'd1: begin
          m_ptr   = int'(d[4:0]) * 256 + (m_ptr % 256);
          m_phase = 0;
        end
        2'd2: begin
          if (m_ptr >= 4096) begin
            e     = {1'b1, 12'(m_ptr % 4096), 8'h00, d};
            push  = 1;
            m_ptr = 4096 + ((m_ptr % 4096) + 1) % 4096;
          end else if (m_phase == 0) begin
            m_latch = int'(d);
            m_phase = 1;
          end else begin
            e       = {1'b0, 12'(m_ptr), 8'(m_latch), d};
            push    = 1;
            m_ptr   = (m_ptr + 1) % 4096;
            m_phase = 0;
          end
        end
        default: begin
          if (d[0]) begin
            sb.delete();
            m_cnt = 0; m_ovf = 0; m_phase = 0;
            pop = 0;
          end
        end
      endcase
    end
    if (push) begin
      if (m_cnt < DEPTH) begin
        sb.push_back(e);
        m_cnt++;
      end else begin
        m_ovf = 1;
      end
    end
    if (pop) m_cnt--;
  endfunction

  function automatic logic [7:0] exp_read(input bit [1:0] r);
    case (r)
      2'd0:    return 8'(m_ptr % 256);
      2'd1:    return 8'(m_ptr / 256);
      2'd2:    return 8'h00;
      default: return {m_cnt == DEPTH, m_cnt == 0, 1'(m_ovf), 1'(m_phase), 1'b0,
                       3'((m_cnt > 7) ? 7 : m_cnt)};
    endcase
  endfunction

  task automatic cycle(input bit cs, input bit we, input bit [1:0] r, input bit [7:0] d);
    cpu_cs = cs; cpu_we = we; cpu_reg = r; cpu_wdata = d;
    model_step(cs, we, r, d);
    @(posedge dot_clk);
    #1;
    cpu_cs = 1'b0; cpu_we = 1'b0;
    check("wr_valid", {31'd0, wr_valid}, {31'd0, m_cnt != 0});
  endtask

  task automatic wr(input bit [1:0] r, input bit [7:0] d);
    cycle(1, 1, r, d);
  endtask

  task automatic rd(input bit [1:0] r, input string nm);
    logic [7:0] e;
    e = exp_read(r);
    cycle(1, 0, r, 8'h00);
    check(nm, {24'd0, cpu_rdata}, {24'd0, e});
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 2'd0, 8'h00);
  endtask

  task automatic drain();
    wr_ready = 1'b1;
    for (int i = 0; i < 60 && sb.size() != 0; i++) idle(1);
    idle(1);
    check("drain_done", sb.size(), 0);
  endtask

  task automatic flush();
    wr_ready = 1'b0;
    wr(2'd3, 8'h01);
  endtask

  // monitor: every accepted beat must match the oldest expected entry,
  // and a stalled head must not change
  initial begin
    logic [28:0] hold;
    logic [28:0] e;
    bit          held;
    held = 0;
    forever begin
      @(negedge dot_clk);
      if (!reset_n || !wr_valid) begin
        held = 0;
      end else begin
        if (held) check("head_stable", {3'd0, head}, {3'd0, hold});
        if (wr_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_errs++;
            $display("FAIL beat_unexpected: got %h expected no beat at %0t", head, $time);
          end else begin
            e = sb.pop_front();
            check("beat", {3'd0, head}, {3'd0, e});
          end
          held = 0;
        end else begin
          hold = head;
          held = 1;
        end
      end
    end
  end

  initial begin
    int op;
    bit [1:0] rr;

    model_reset();
    repeat (3) @(posedge dot_clk);
    #1 reset_n = 1'b1;
    check("reset_rdata", {24'd0, cpu_rdata}, 32'h0);
    check("reset_valid", {31'd0, wr_valid}, 32'h0);
    rd(2'd3, "reset_status");
    check("reset_status_k", {24'd0, cpu_rdata}, 32'h40);

    // single name entry
    wr_ready = 1'b1;
    wr(2'd0, 8'h10); wr(2'd1, 8'h00); wr(2'd2, 8'h41); wr(2'd2, 8'h07);
    idle(2);
    rd(2'd3, "name_status");
    check("name_status_k", {24'd0, cpu_rdata}, 32'h40);

    // tile stream under backpressure
    wr_ready = 1'b0;
    wr(2'd1, 8'h10); wr(2'd0, 8'h00);
    wr(2'd2, 8'hAA); wr(2'd2, 8'h55); wr(2'd2, 8'hFF);
    rd(2'd3, "tile_status");
    check("tile_status_k", {24'd0, cpu_rdata}, 32'h03);
    idle(2);
    check("tile_head_tgt", {31'd0, wr_target}, 32'h1);
    check("tile_head_addr", {20'd0, wr_addr}, 32'h000);
    check("tile_head_data", {16'd0, wr_data}, 32'h00AA);
    drain();

    // overflow
    wr_ready = 1'b0;
    wr(2'd1, 8'h10); wr(2'd0, 8'h00);
    for (int i = 0; i < 5; i++) wr(2'd2, 8'(8'h30 + i));
    rd(2'd3, "ovf_status");
    check("ovf_status_k", {24'd0, cpu_rdata}, 32'hA4);
    rd(2'd0, "ovf_ptr_lo");
    check("ovf_ptr_lo_k", {24'd0, cpu_rdata}, 32'h05);
    rd(2'd1, "ovf_ptr_hi");
    check("ovf_ptr_hi_k", {24'd0, cpu_rdata}, 32'h10);
    drain();
    rd(2'd3, "ovf_sticky");
    check("ovf_sticky_k", {24'd0, cpu_rdata}, 32'h60);
    flush();

    // pointer wrap on the name target
    wr_ready = 1'b1;
    wr(2'd1, 8'h0F); wr(2'd0, 8'hFF); wr(2'd2, 8'h12); wr(2'd2, 8'h34);
    rd(2'd0, "wrap_lo");
    check("wrap_lo_k", {24'd0, cpu_rdata}, 32'h00);
    rd(2'd1, "wrap_hi");
    check("wrap_hi_k", {24'd0, cpu_rdata}, 32'h00);
    drain();

    // flush in the middle of a name pair
    wr_ready = 1'b0;
    wr(2'd2, 8'h9A);
    rd(2'd3, "midpair_status");
    check("midpair_status_k", {24'd0, cpu_rdata}, 32'h50);
    flush();
    rd(2'd3, "flush_status");
    check("flush_status_k", {24'd0, cpu_rdata}, 32'h40);
    wr(2'd2, 8'hBC); wr(2'd2, 8'hDE);
    rd(2'd3, "after_flush_status");
    check("after_flush_status_k", {24'd0, cpu_rdata}, 32'h01);
    drain();

    // asynchronous reset with entries queued
    wr_ready = 1'b0;
    wr(2'd1, 8'h10); wr(2'd0, 8'h40); wr(2'd2, 8'h11); wr(2'd2, 8'h22);
    idle(1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_valid", {31'd0, wr_valid}, 32'h0);
    check("async_reset_rdata", {24'd0, cpu_rdata}, 32'h0);
    model_reset();
    @(posedge dot_clk);
    #1 reset_n = 1'b1;
    rd(2'd3, "post_reset_status");
    check("post_reset_status_k", {24'd0, cpu_rdata}, 32'h40);
    rd(2'd0, "post_reset_lo");
    rd(2'd1, "post_reset_hi");
    check("post_reset_hi_k", {24'd0, cpu_rdata}, 32'h00);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      wr_ready = ($urandom_range(0, 3) != 0);
      op = $urandom_range(0, 99);
      rr = 2'($urandom_range(0, 3));
      if (op < 58)      wr(2'd2, 8'($urandom));
      else if (op < 66) wr(2'd0, 8'($urandom));
      else if (op < 72) wr(2'd1, 8'($urandom));
      else if (op < 90) rd(rr, "rand_read");
      else if (op < 93) flush();
      else              idle(1);
    end
    drain();
    rd(2'd3, "final_status");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
